// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared constants and types for the byte-serial ALU datapath.
//   BYTE_W  : width of the shared adder slice (one byte per RUN cycle)
//   state_t : control states of the serial add/subtract sequencer
package alu_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage : alu_pkg

// File: rtl/cla8_slice.sv
// cla8_slice
//   Combinational 8-bit carry-lookahead adder slice.
//   Ports:
//     a, b  in  BYTE_W  addend bytes
//     cin   in  1       carry in
//     s     out BYTE_W  sum byte
//     cout  out 1       carry out of bit BYTE_W-1
module cla8_slice
  import alu_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] s,
  output logic              cout
);

  logic [BYTE_W-1:0] g;
  logic [BYTE_W-1:0] p;
  logic [BYTE_W:0]   c;
  logic              c_acc;
  logic              p_acc;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is expanded as a flat sum of generate terms gated by the
  // propagate chain above them, so no carry depends on a lower carry signal.
  always_comb begin
    c     = '0;
    c_acc = 1'b0;
    p_acc = 1'b0;
    c[0]  = cin;
    for (int i = 0; i < BYTE_W; i++) begin
      c_acc = g[i];
      p_acc = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c_acc = c_acc | (p_acc & g[j]);
        p_acc = p_acc & p[j];
      end
      c[i+1] = c_acc | (p_acc & cin);
    end
  end

  assign s    = p ^ c[BYTE_W-1:0];
  assign cout = c[BYTE_W];

endmodule : cla8_slice

// File: rtl/byte_serial_addsub.sv
// byte_serial_addsub
//   Multi-cycle WIDTH-bit add/subtract unit built around one shared 8-bit
//   CLA slice. Operands are accepted in IDLE, processed one byte per cycle
//   (LSB first) in RUN with the carry held in a register, and the result is
//   presented in DONE until the consumer takes it.
//   Optional feature macro: SERIAL_ADD_FLAGS_EN adds the ovf and zero outputs.
//   Ports:
//     clk, rst_n          clock (rising edge), asynchronous active-low reset
//     in_valid, in_ready  operand handshake (in_ready only in IDLE)
//     a, b, sub           operands; sub=1 computes a-b, sub=0 computes a+b
//     out_valid, out_ready result handshake (out_valid only in DONE)
//     sum, cout           result and carry out (for sub, cout = no borrow)
//     ovf, zero           signed overflow, sum==0 (flags build only)
module byte_serial_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_FLAGS_EN
  ,
  output logic             ovf,
  output logic             zero
`endif
);

  localparam int NBYTES = WIDTH / BYTE_W;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  generate
    if ((WIDTH < BYTE_W) || ((WIDTH % BYTE_W) != 0)) begin : g_width_check
      $error("byte_serial_addsub: WIDTH must be a non-zero multiple of 8");
    end
  endgenerate

  state_t                         state;
  logic [IDX_W-1:0]               idx;
  logic                           carry;
  logic [NBYTES-1:0][BYTE_W-1:0]  a_q;
  logic [NBYTES-1:0][BYTE_W-1:0]  b_q;
  logic [NBYTES-1:0][BYTE_W-1:0]  sum_q;
  logic [NBYTES-1:0][BYTE_W-1:0]  sum_next;

  logic [BYTE_W-1:0] slice_a;
  logic [BYTE_W-1:0] slice_b;
  logic [BYTE_W-1:0] slice_s;
  logic              slice_cout;

  // The current byte lane feeds the shared slice; sum_next is the result
  // register with that lane replaced, used both for the write-back and for
  // the zero flag on the final byte.
  always_comb begin
    slice_a       = a_q[idx];
    slice_b       = b_q[idx];
    sum_next      = sum_q;
    sum_next[idx] = slice_s;
  end

  cla8_slice u_slice (
    .a   (slice_a),
    .b   (slice_b),
    .cin (carry),
    .s   (slice_s),
    .cout(slice_cout)
  );

  assign sum = sum_q;

  // Sequencer: B is stored pre-inverted and the carry seeded with sub, so
  // subtraction is a plain two's-complement add through the same slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      cout      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
`ifdef SERIAL_ADD_FLAGS_EN
      ovf       <= 1'b0;
      zero      <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b ^ {WIDTH{sub}};
            carry    <= sub;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= ST_RUN;
          end
        end

        ST_RUN: begin
          sum_q <= sum_next;
          carry <= slice_cout;
          if (idx == LAST_IDX) begin
            cout      <= slice_cout;
            out_valid <= 1'b1;
            state     <= ST_DONE;
`ifdef SERIAL_ADD_FLAGS_EN
            // Carry into the MSB recovered from the MSB sum bit and its inputs.
            ovf  <= a_q[NBYTES-1][BYTE_W-1] ^ b_q[NBYTES-1][BYTE_W-1]
                    ^ slice_s[BYTE_W-1] ^ slice_cout;
            zero <= (sum_next == '0);
`endif
          end else begin
            idx <= idx + 1'b1;
          end
        end

        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : byte_serial_addsub
